// File: rtl/sram_ctrl_pkg.sv
// Shared types and width helpers for the SRAM controller.
//   state_e      : controller FSM states (init / run)
//   be_width     : byte-enable width for a given data width
//   credit_width : width of a counter that can hold 0..rsp_depth
package sram_ctrl_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned be_width(input int unsigned data_width);
        return (data_width + 7) / 8;
    endfunction

    function automatic int unsigned credit_width(input int unsigned rsp_depth);
        return $clog2(rsp_depth + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Response FIFO holding SRAM read data that the consumer has not yet taken.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wr_data   : enqueue one word
//   pop             : dequeue the head (only meaningful when !empty)
//   rd_data         : head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries
module sram_ctrl_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned RSP_DEPTH  = 2,
    localparam int unsigned CW         = credit_width(RSP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_data;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign full    = (count_q == CW'(RSP_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/sram_ctrl.sv
// Initiator-side controller for a single-port byte-enable SRAM macro.
// Turns a valid/ready request channel into fixed-latency SRAM accesses and
// returns read data on a valid/ready response channel, buffering it in a
// credit-limited FIFO so nothing is lost while the consumer stalls.
// Ports:
//   clk_i, rst_ni                   : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         : request handshake
//   req_we_i/addr/wdata/be          : request payload
//   rsp_valid_o/rsp_ready_i         : read-response handshake
//   rsp_rdata_o                     : read data
//   sram_req_o/we/addr/wdata/be     : SRAM command port
//   sram_rdata_i                    : SRAM read data (READ_LAT cycles after issue)
//   init_done_o                     : high once requests are being accepted
// Optional build macro SRAM_CTRL_INIT_SCRUB_EN: zero-fill the whole SRAM
// during INIT before accepting any request.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned NUM_WORDS  = 1024,
    parameter  int unsigned READ_LAT   = 1,
    parameter  int unsigned RSP_DEPTH  = 2,
    localparam int unsigned AW         = $clog2(NUM_WORDS),
    localparam int unsigned BW         = be_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  init_done_o
);

    localparam int unsigned   CW      = credit_width(RSP_DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);

    state_e state_q, state_d;
    logic   run;
    logic   init_exit;

    assign run = (state_q == StRun);

`ifdef SRAM_CTRL_INIT_SCRUB_EN
    logic [AW-1:0] scrub_addr_q, scrub_addr_d;
    logic          scrub_last;
    logic          scrub_active;

    // Gated with reset so the SRAM port stays quiet while reset is held.
    assign scrub_active = (state_q == StInit) && rst_ni;
    assign scrub_last   = (scrub_addr_q == AW'(NUM_WORDS - 1));
    assign init_exit    = scrub_last;

    always_comb begin
        scrub_addr_d = scrub_addr_q;
        if (state_q == StInit) begin
            scrub_addr_d = scrub_last ? '0 : scrub_addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scrub_addr_q <= '0;
        end else begin
            scrub_addr_q <= scrub_addr_d;
        end
    end
`else
    assign init_exit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: if (init_exit) state_d = StRun;
            StRun:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Credits: reads in flight plus buffered responses. Using registered
    // counts means a credit freed by a pop is only reusable next cycle.
    logic [READ_LAT-1:0]   pipe_q, pipe_d;
    logic [CW:0]           inflight_cnt;
    logic [CW:0]           credits_used;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  req_fire, rd_issue, rd_arrive;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            inflight_cnt = inflight_cnt + {{CW{1'b0}}, pipe_q[i]};
        end
    end

    assign credits_used = inflight_cnt + {1'b0, fifo_count};
    assign req_ready_o  = run && (req_we_i || (credits_used < DEPTH_C));
    assign req_fire     = req_valid_i && req_ready_o;
    assign rd_issue     = req_fire && !req_we_i;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
`ifdef SRAM_CTRL_INIT_SCRUB_EN
        if (scrub_active) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = scrub_addr_q;
            sram_be_o   = '1;
        end else
`endif
        if (req_fire) begin
            sram_req_o   = 1'b1;
            sram_we_o    = req_we_i;
            sram_addr_o  = req_addr_i;
            sram_wdata_o = req_wdata_i;
            sram_be_o    = req_be_i;
        end
    end

    // Valid bit per read, aligned with the SRAM's fixed read latency.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = rd_issue;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign rd_arrive = pipe_q[READ_LAT-1];

    // Empty FIFO: arriving data bypasses straight to the output and is only
    // stored if the consumer does not take it this cycle.
    assign fifo_pop    = !fifo_empty && rsp_ready_i;
    assign fifo_push   = rd_arrive && !(fifo_empty && rsp_ready_i);
    assign rsp_valid_o = !fifo_empty || rd_arrive;
    assign rsp_rdata_o = !fifo_empty ? fifo_head : (rd_arrive ? sram_rdata_i : '0);
    assign init_done_o = run;

    sram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (fifo_push),
        .wr_data (sram_rdata_i),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifndef SYNTHESIS
    // Credits make this unreachable; firing means the credit logic is broken.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(fifo_push && fifo_full && !fifo_pop))
        else $error("sram_ctrl: push to full response FIFO");
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (READ_LAT=2, NUM_WORDS=16, RSP_DEPTH=2) with a
// behavioural byte-enable SRAM model. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_sram_ctrl;

    localparam int unsigned RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic        sram_req, sram_we;
    logic [3:0]  sram_addr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [7:0]  sram_be;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [16];
    logic [63:0] rd_s1, rd_s2;
    logic [63:0] shadow [16];
    logic [3:0]  addr_tab [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7};

    always #5 clk = ~clk;

    sram_ctrl #(
        .DATA_WIDTH (64),
        .NUM_WORDS  (16),
        .READ_LAT   (RL),
        .RSP_DEPTH  (2)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata),
        .init_done_o  (init_done)
    );

    // SRAM macro model: sequential write, two-stage registered read.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                rd_s1 <= mem[sram_addr];
            end
        end
        rd_s2 <= rd_s1;
    end
    assign sram_rdata = rd_s2;

    task automatic drive_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic issue_read(input logic [3:0] a);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0; req_be = '0;
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive_idle();
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
            errors++;
            $display("FAIL reset_req_side: got ready=%b req=%b we=%b addr=%h wdata=%h be=%h, required all 0",
                     req_ready, sram_req, sram_we, sram_addr, sram_wdata, sram_be);
        end
        checks++;
        if ({rsp_valid, rsp_rdata, init_done} !== '0) begin
            errors++;
            $display("FAIL reset_rsp_side: got valid=%b rdata=%h init_done=%b, required all 0",
                     rsp_valid, rsp_rdata, init_done);
        end
        rst_n = 1'b1;
`ifdef SRAM_CTRL_INIT_SCRUB_EN
        for (int a = 0; a < 16; a++) begin
            #1;
            checks++;
            if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'(a) ||
                sram_wdata !== 64'd0 || sram_be !== 8'hFF || req_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL scrub_write_%0d: got req=%b we=%b addr=%h wdata=%h be=%h ready=%b done=%b, required 1 1 %h 0 ff 0 0",
                         a, sram_req, sram_we, sram_addr, sram_wdata, sram_be, req_ready, init_done, a);
            end
            @(negedge clk);
        end
        drive_idle();
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL scrub_init_done: got %b, required 1", init_done);
        end
`else
        drive_idle();
        #1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_cycle1: got init_done=%b, required 0", init_done);
        end
        @(negedge clk); #1;
        checks++;
        if (init_done !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_cycle2: got init_done=%b ready=%b, required 1 1", init_done, req_ready);
        end
`endif
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5;
        req_wdata = 64'hDEADBEEF_CAFEF00D; req_be = 8'hFF;
        shadow[5] = 64'hDEADBEEF_CAFEF00D;
        #1;
        checks++;
        if (req_ready !== 1'b1 || sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'd5 ||
            sram_wdata !== 64'hDEADBEEF_CAFEF00D || sram_be !== 8'hFF) begin
            errors++;
            $display("FAIL write_passthru: got ready=%b req=%b we=%b addr=%h wdata=%h be=%h, required 1 1 1 5 deadbeefcafef00d ff",
                     req_ready, sram_req, sram_we, sram_addr, sram_wdata, sram_be);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        #1;
        checks++;
        if (req_ready !== 1'b1 || sram_req !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 4'd5) begin
            errors++;
            $display("FAIL read_issue: got ready=%b req=%b we=%b addr=%h, required 1 1 0 5",
                     req_ready, sram_req, sram_we, sram_addr);
        end
        @(posedge clk); #1;
        drive_idle();
        for (int k = 1; k <= RL; k++) begin
            @(negedge clk); #1;
            if (k < RL) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL read_early_%0d: got rsp_valid=%b, required 0", k, rsp_valid);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin
                    errors++;
                    $display("FAIL read_data: got valid=%b rdata=%h, required 1 deadbeefcafef00d",
                             rsp_valid, rsp_rdata);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_consumed: got rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_partial_write();
        write_word(4'd5, 64'h11111111_22222222, 8'h0F);
        issue_read(4'd5);   // back-to-back with the write
        repeat (RL) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_22222222) begin
            errors++;
            $display("FAIL partial_write: got valid=%b rdata=%h, required 1 deadbeef22222222",
                     rsp_valid, rsp_rdata);
        end
    endtask

`ifdef SRAM_CTRL_INIT_SCRUB_EN
    task automatic test_scrub_read();
        rsp_ready = 1'b1;
        issue_read(4'd9);
        repeat (RL) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL scrub_read: got valid=%b rdata=%h, required 1 0", rsp_valid, rsp_rdata);
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [63:0] exp [2];
        int idx;
        write_word(4'd1, 64'hA1A1A1A1_00000001, 8'hFF);
        write_word(4'd2, 64'hA2A2A2A2_00000002, 8'hFF);
        write_word(4'd3, 64'hA3A3A3A3_00000003, 8'hFF);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_rd1_ready: got %b, required 1", req_ready);
        end
        @(negedge clk);
        req_addr = 4'd2;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_rd2_ready: got %b, required 1", req_ready);
        end
        @(negedge clk);
        req_addr = 4'd3;
        #1;
        checks++;
        if (req_ready !== 1'b0 || sram_req !== 1'b0 || rsp_valid !== 1'b1 ||
            rsp_rdata !== 64'hA1A1A1A1_00000001) begin
            errors++;
            $display("FAIL bp_rd3_block: got ready=%b req=%b valid=%b rdata=%h, required 0 0 1 a1a1a1a100000001",
                     req_ready, sram_req, rsp_valid, rsp_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 64'hA1A1A1A1_00000001) begin
                errors++;
                $display("FAIL bp_hold_%0d: got ready=%b valid=%b rdata=%h, required 0 1 a1a1a1a100000001",
                         c, req_ready, rsp_valid, rsp_rdata);
            end
        end
        // Popping this cycle frees a credit only from the next cycle on.
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || sram_req !== 1'b0 || rsp_rdata !== 64'hA1A1A1A1_00000001) begin
            errors++;
            $display("FAIL bp_same_cycle_credit: got ready=%b req=%b rdata=%h, required 0 0 a1a1a1a100000001",
                     req_ready, sram_req, rsp_rdata);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || sram_req !== 1'b1 || sram_addr !== 4'd3 ||
            rsp_rdata !== 64'hA2A2A2A2_00000002) begin
            errors++;
            $display("FAIL bp_rd3_accept: got ready=%b req=%b addr=%h rdata=%h, required 1 1 3 a2a2a2a200000002",
                     req_ready, sram_req, sram_addr, rsp_rdata);
        end
        @(posedge clk); #1;
        drive_idle();
        exp[0] = 64'hA2A2A2A2_00000002;
        exp[1] = 64'hA3A3A3A3_00000003;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid) begin
                checks++;
                if (idx >= 2) begin
                    errors++;
                    $display("FAIL bp_extra_rsp: got rdata=%h, required no response", rsp_rdata);
                end else if (rsp_rdata !== exp[idx]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %h, required %h", idx, rsp_rdata, exp[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL bp_rsp_count: got %0d, required 2", idx);
        end
    endtask

    task automatic test_interleave();
        logic [63:0] exp_q [$];
        logic        stall_prev;
        logic [63:0] stall_data;
        write_word(4'd7, 64'h7777_0000_7777_0000, 8'hFF);
        stall_prev = 1'b0;
        stall_data = '0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (cyc < 60) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = ($urandom_range(0, 2) == 0);
                req_addr  = addr_tab[$urandom_range(0, 4)];
                req_wdata = {$urandom, $urandom};
                req_be    = 8'($urandom);
            end else begin
                drive_idle();
            end
            rsp_ready = (cyc >= 75) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== stall_data) begin
                    errors++;
                    $display("FAIL il_hold_c%0d: got valid=%b rdata=%h, required 1 %h",
                             cyc, rsp_valid, rsp_rdata, stall_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL il_unexpected_c%0d: got rdata=%h, required no response", cyc, rsp_rdata);
                end else begin
                    if (rsp_rdata !== exp_q[0]) begin
                        errors++;
                        $display("FAIL il_data_c%0d: got %h, required %h", cyc, rsp_rdata, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            stall_data = rsp_rdata;
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int b = 0; b < 8; b++) begin
                        if (req_be[b]) shadow[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(shadow[req_addr]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL il_drain: got %0d responses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_in_flight();
        bit done;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
        @(negedge clk);
        req_addr = 4'd2;
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rif_pre_valid: got %b, required 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rif_async: got valid=%b rdata=%h ready=%b, required 0 0 0",
                     rsp_valid, rsp_rdata, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk); #1;
            done = init_done;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rif_init_timeout: got init_done=%b, required 1", init_done);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rif_stale_%0d: got rsp_valid=%b, required 0", c, rsp_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        rsp_ready = 1'b0;
        test_reset();
`ifdef SRAM_CTRL_INIT_SCRUB_EN
        test_scrub_read();
`endif
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_interleave();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator-side controller for the single-port byte-enable SRAM macro interface (req/we/addr/wdata/be in, rdata out with fixed read latency).
- Converts a decoupled valid/ready request channel and valid/ready read-response channel into the SRAM's fixed-latency, non-backpressurable port.
- Holds a credit-limited response FIFO so SRAM read data is never lost when the consumer stalls.
- Sits between cache/DMA-style clients and the SRAM wrapper.

Parameters:
- DATA_WIDTH, 64, data width in bits; byte enables are (DATA_WIDTH+7)/8 wide.
- NUM_WORDS, 1024, SRAM depth; address width is $clog2(NUM_WORDS).
- READ_LAT, 1, SRAM read latency in cycles; legal values are 1 and 2, and must match the macro's output-register setting.
- RSP_DEPTH, 2, response FIFO entries; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  $clog2(NUM_WORDS)  word address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_be_i  in  (DATA_WIDTH+7)/8  byte enables.
- rsp_valid_o  out  1  read data valid.
- rsp_ready_i  in  1  consumer ready.
- rsp_rdata_o  out  DATA_WIDTH  read data.
- sram_req_o  out  1  SRAM chip select.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  $clog2(NUM_WORDS)  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_be_o  out  (DATA_WIDTH+7)/8  SRAM byte enables.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data.
- init_done_o  out  1  controller is accepting requests.

Behaviour:
- Reset values: all outputs 0 during reset, including FIFO, in-flight pipe and counters. Reset asserted mid-operation drops in-flight reads and buffered responses.
- States: INIT, RUN.
  - Without the optional feature, INIT lasts exactly one cycle after reset release, then RUN.
  - init_done_o = (state==RUN).
- Request path (RUN):
  - sram_req_o = req_valid_i && req_ready_o, combinational.
  - sram_we_o/addr/wdata/be pass through combinationally; they are 0 when sram_req_o=0.
- Writes:
  - req_ready_o=1 in RUN regardless of credits.
  - No response is generated.
- Reads:
  - credits_used = in-flight reads + FIFO count.
  - A read is accepted only when credits_used < RSP_DEPTH.
  - A credit released in the same cycle is not reusable until the next cycle.
  - Therefore req_ready_o = RUN && (req_we_i || credits_used < RSP_DEPTH).
- In-flight pipe: READ_LAT-deep shift register of valid bits. A read issued at cycle T has sram_rdata_i sampled at T+READ_LAT.
- Response bypass:
  - If the FIFO is empty when read data arrives, rsp_valid_o=1 and rsp_rdata_o=sram_rdata_i in that cycle.
  - If rsp_ready_i=1, the data is consumed and not pushed; otherwise it is pushed.
- Non-empty FIFO: rsp_valid_o=1 and rsp_rdata_o=head. New arriving data is pushed behind the head, keeping order.
- Simultaneous push and pop on a full FIFO is legal. Overflow is impossible by credit construction; a simulation assertion flags a push to a full FIFO.
- Read-after-write to the same address on consecutive cycles returns the new data, because the SRAM is sequential.
- rsp_rdata_o holds its value while rsp_valid_o && !rsp_ready_i.

Optional Feature:
- Macro: SRAM_CTRL_INIT_SCRUB_EN.
- When defined:
  - INIT walks addr 0..NUM_WORDS-1, one write per cycle, with sram_we_o=1, wdata=0 and be all-ones.
  - req_ready_o=0 throughout INIT.
  - init_done_o rises the cycle after the write to NUM_WORDS-1.
  - The scrub address counter wraps to 0 and stops.
  - Reset mid-scrub restarts the scrub from address 0.
- When undefined: no scrub logic; behaviour is as in Behaviour.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum (INIT, RUN);
  - a function computing the byte-enable width;
  - a credit counter width constant, $clog2(RSP_DEPTH+1) as a function of the parameter.
- One sub-module: sram_ctrl_rsp_fifo, a parameterized RSP_DEPTH×DATA_WIDTH FIFO with full/empty/count outputs.

Test Plan:
- Directed cases:
  - Reset release, macro undefined -> init_done_o=1 on cycle 2. Write 0xDEADBEEF_CAFEF00D to addr 5 with be=0xFF, then read addr 5 with rsp_ready_i=1 -> rsp_valid_o at issue+READ_LAT with that data.
  - Partial write: be=0x0F, data 0x11111111_22222222 over 0xDEADBEEF_CAFEF00D at addr 5 -> read returns 0xDEADBEEF_22222222.
  - RSP_DEPTH=2, rsp_ready_i=0, back-to-back reads of addr 1,2,3 -> two accepted; req_ready_o=0 for the third until rsp_ready_i=1 pops one; responses arrive in order 1,2,3.
  - With READ_LAT=2, interleave write addr 7 and reads under random rsp_ready_i -> no response is lost or reordered, and the FIFO never overflows (assertion silent).
  - Reset asserted with 2 reads in flight -> rsp_valid_o=0 immediately, and no stale response appears after reset release.
  - SRAM_CTRL_INIT_SCRUB_EN defined with NUM_WORDS=16 -> 16 zero-writes at addresses 0..15, init_done_o high at cycle 17, every subsequent read returns 0.
